// File: rtl/modn_cascade_counter.sv
// Parametrised MOD-N counter of DIGITS cascaded digits: up/down, enable, load, clear, tc, sticky ovf.
// Optional: define MODN_CNT_SATURATE_EN to hold at the full-scale ends instead of wrapping.
module modn_cascade_counter #(
  parameter int MODULUS = 10,
  parameter int DIGITS  = 2,
  localparam int DW     = $clog2(MODULUS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic                 en,
  input  logic                 up,
  output logic [DIGITS*DW-1:0] q,
  output logic                 tc,
  output logic                 ovf
);

  localparam logic [DW-1:0] MAX_DIG = DW'(MODULUS - 1);
  localparam logic [DW:0]   MOD_EXT = (DW + 1)'(MODULUS);

  generate
    if (MODULUS < 2 || MODULUS > 16 || DIGITS < 1 || DIGITS > 8) begin : g_bad_param
      $error("modn_cascade_counter: illegal parameters MODULUS=%0d DIGITS=%0d", MODULUS, DIGITS);
    end
  endgenerate

  logic [DIGITS*DW-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS-1:0]    dig_max, dig_zero;
  logic [DIGITS-1:0]    carry;
  logic                 all_max, all_zero;
  logic                 sat_hold;

  always_comb begin
    dig_max  = '0;
    dig_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_max[i]  = (cnt_q[i*DW +: DW] == MAX_DIG);
      dig_zero[i] = (cnt_q[i*DW +: DW] == '0);
    end
  end

  assign all_max  = &dig_max;
  assign all_zero = &dig_zero;

  // carry[i]: every digit below i sits at its rollover value for the current direction.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      carry[i] = carry[i-1] & (up ? dig_max[i-1] : dig_zero[i-1]);
    end
  end

`ifdef MODN_CNT_SATURATE_EN
  assign sat_hold = up ? all_max : all_zero;
`else
  assign sat_hold = 1'b0;
`endif

  assign tc = en & ~clr & ~load & (up ? all_max : all_zero);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        if ({1'b0, load_val[i*DW +: DW]} >= MOD_EXT) begin
          cnt_d[i*DW +: DW] = MAX_DIG;
        end else begin
          cnt_d[i*DW +: DW] = load_val[i*DW +: DW];
        end
      end
    end else if (en && !sat_hold) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry[i]) begin
          if (up) begin
            cnt_d[i*DW +: DW] = dig_max[i] ? '0 : cnt_q[i*DW +: DW] + DW'(1);
          end else begin
            cnt_d[i*DW +: DW] = dig_zero[i] ? MAX_DIG : cnt_q[i*DW +: DW] - DW'(1);
          end
        end
      end
    end
  end

  // tc is already gated by clr and load, so a load leaves the flag untouched.
  assign ovf_d = clr ? 1'b0 : (ovf_q | tc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Self-checking bench for modn_cascade_counter (MODULUS=10, DIGITS=2) using a value-level reference model.
module tb_modn_cascade_counter;

  localparam int MODULUS = 10;
  localparam int DIGITS  = 2;
  localparam int DW      = $clog2(MODULUS);
  localparam int W       = DIGITS * DW;
  localparam int TOTAL   = MODULUS ** DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  int m_val = 0;
  bit m_ovf = 1'b0;

  logic [W:0] exp_q[$];

  modn_cascade_counter #(.MODULUS(MODULUS), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q), .tc(tc), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] enc(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = DW'(t % MODULUS);
      t = t / MODULUS;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [W-1:0] lv);
    int v, mul, d;
    v = 0;
    mul = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[i*DW +: DW]);
      if (d >= MODULUS) d = MODULUS - 1;
      v += d * mul;
      mul *= MODULUS;
    end
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;
    #1;
    m_val = 0;
    m_ovf = 1'b0;
    check("rst_q", 32'(q), 32'(enc(0)));
    check("rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: apply one cycle of controls, check tc, push expectation, compare after the edge
  task automatic drive_cycle(input logic c, input logic l, input logic [W-1:0] lv,
                             input logic e, input logic u);
    bit   exp_tc;
    logic [W:0] got_exp;
    clr = c; load = l; load_val = lv; en = e; up = u;
    #1;
    exp_tc = e && !c && !l && (u ? (m_val == TOTAL - 1) : (m_val == 0));
    check("tc", 32'(tc), 32'(exp_tc));
    if (c) begin
      m_val = 0;
      m_ovf = 1'b0;
    end else if (l) begin
      m_val = clamp_val(lv);
    end else if (e) begin
      if (exp_tc) m_ovf = 1'b1;
`ifdef MODN_CNT_SATURATE_EN
      if (!exp_tc) m_val = u ? m_val + 1 : m_val - 1;
`else
      m_val = u ? (m_val + 1) % TOTAL : (m_val + TOTAL - 1) % TOTAL;
`endif
    end
    exp_q.push_back({m_ovf, enc(m_val)});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      got_exp = exp_q.pop_front();
      check("q", 32'(q), 32'(got_exp[W-1:0]));
      check("ovf", 32'(ovf), 32'(got_exp[W]));
    end
  endtask

  initial begin
    do_reset();

    // full up sweep through wrap
    for (int i = 0; i < TOTAL; i++) drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("sweep_end_ovf", 32'(ovf), 32'(1));

    // underflow from zero after a clear
    drive_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // load has priority over en; then count across a digit boundary both ways
    drive_cycle(1'b0, 1'b1, 8'h47, 1'b1, 1'b1);
    check("load47", 32'(q), 32'h47);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("up_to_50", 32'(q), 32'h50);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("down_to_49", 32'(q), 32'h49);

    // idle holds
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // clamped load, then wrap
    drive_cycle(1'b0, 1'b1, 8'hAF, 1'b0, 1'b1);
    check("clamp99", 32'(q), 32'h99);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // clr beats load
    drive_cycle(1'b0, 1'b1, 8'h63, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 8'h12, 1'b1, 1'b1);
    check("clr_load_q", 32'(q), 32'h00);

    // saturation / wrap at the top from 0x98
    drive_cycle(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset mid-cycle with a pending load
    drive_cycle(1'b0, 1'b1, 8'h25, 1'b0, 1'b1);
    load = 1'b1; load_val = 8'h33; en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q", 32'(q), 32'h00);
    check("async_rst_ovf", 32'(ovf), 32'(0));
    m_val = 0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_q", 32'(q), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0; en = 1'b0;

    // random mix of controls
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                  W'($urandom_range(0, (1 << W) - 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
    end

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
